// File: rtl/prefetch_queue.sv
// 8088-style instruction prefetch queue: a byte FIFO between the bus interface and the
// execution unit that tracks the linear address of the head byte and of the next fetch.
module prefetch_queue #(
  parameter int                DEPTH      = 4,
  parameter int                ADDR_W     = 20,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 20'hFFFF0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         push,
  input  logic [7:0]                   pushData,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            flushAddress,
  input  logic                         suspend,
  output logic [7:0]                   prefetchTop,
  output logic [ADDR_W-1:0]            prefetchTopLinearAddress,
  output logic [ADDR_W-1:0]            fetchAddress,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         prefetchEmpty,
  output logic                         prefetchFull,
  output logic                         fetchRequest,
  output logic                         overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]        mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] head_addr_r;
  logic [ADDR_W-1:0] fetch_addr_r;
  logic              overflow_r;

  logic empty_s;
  logic full_s;
  logic pop_ok_s;
  logic push_ok_s;

  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign full_s    = (count_r == CNT_W'(DEPTH));
  // A pop frees a slot in the same cycle, so a full queue may still take a byte.
  assign pop_ok_s  = pop && !empty_s;
  assign push_ok_s = push && (!full_s || pop_ok_s);

  // Queue storage, pointers, count, address trackers and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      head_addr_r  <= RESET_ADDR;
      fetch_addr_r <= RESET_ADDR;
      overflow_r   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      head_addr_r  <= flushAddress;
      fetch_addr_r <= flushAddress;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= pushData;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        fetch_addr_r    <= fetch_addr_r + ADDR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r    <= rd_ptr_r + PTR_W'(1);
        head_addr_r <= head_addr_r + ADDR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (push && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign prefetchTop              = empty_s ? 8'h00 : mem_r[rd_ptr_r];
  assign prefetchTopLinearAddress = head_addr_r;
  assign fetchAddress             = fetch_addr_r;
  assign count                    = count_r;
  assign prefetchEmpty            = empty_s;
  assign prefetchFull             = full_s;
  assign fetchRequest             = !full_s && !suspend && !flush;
  assign overflow                 = overflow_r;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: a vector table applied edge by edge, plus
// hand-written sequences for full-queue streaming and the no-bypass head timing.
module tb_prefetch_queue;

  logic        CLK = 1'b0;
  logic        RESET, push, pop, flush, suspend;
  logic [7:0]  pushData;
  logic [19:0] flushAddress;
  logic [7:0]  prefetchTop;
  logic [19:0] prefetchTopLinearAddress, fetchAddress;
  logic [2:0]  count;
  logic        prefetchEmpty, prefetchFull, fetchRequest, overflow;

  int checks = 0;
  int errors = 0;

  prefetch_queue #(.DEPTH(4), .ADDR_W(20), .RESET_ADDR(20'hFFFF0)) dut (
    .CLK(CLK), .RESET(RESET), .push(push), .pushData(pushData), .pop(pop),
    .flush(flush), .flushAddress(flushAddress), .suspend(suspend),
    .prefetchTop(prefetchTop), .prefetchTopLinearAddress(prefetchTopLinearAddress),
    .fetchAddress(fetchAddress), .count(count), .prefetchEmpty(prefetchEmpty),
    .prefetchFull(prefetchFull), .fetchRequest(fetchRequest), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, psh;
    logic [7:0]  d;
    logic        pp, fl;
    logic [19:0] fa;
    logic        sus;
    logic [2:0]  cnt;
    logic [7:0]  top;
    logic [19:0] head, fetch;
    logic        ovf, freq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic psh, logic [7:0] d, logic pp, logic fl,
                             logic [19:0] fa, logic sus, logic [2:0] cnt, logic [7:0] top,
                             logic [19:0] head, logic [19:0] fetch, logic ovf, logic freq);
    vec_t r;
    r.rst = rst; r.psh = psh; r.d = d; r.pp = pp; r.fl = fl; r.fa = fa; r.sus = sus;
    r.cnt = cnt; r.top = top; r.head = head; r.fetch = fetch; r.ovf = ovf; r.freq = freq;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic psh, logic [7:0] d, logic pp, logic fl,
                       logic [19:0] fa, logic sus);
    RESET = rst; push = psh; pushData = d; pop = pp; flush = fl;
    flushAddress = fa; suspend = sus;
  endtask

  task automatic check_state(string tag, logic [2:0] cnt, logic [7:0] top, logic [19:0] head,
                             logic [19:0] fetch, logic ovf, logic freq);
    chk({tag, " count"}, 32'(count), 32'(cnt));
    chk({tag, " top"}, 32'(prefetchTop), 32'(top));
    chk({tag, " head_addr"}, 32'(prefetchTopLinearAddress), 32'(head));
    chk({tag, " fetch_addr"}, 32'(fetchAddress), 32'(fetch));
    chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, " fetch_req"}, 32'(fetchRequest), 32'(freq));
    chk({tag, " empty"}, 32'(prefetchEmpty), 32'(cnt == 3'd0));
    chk({tag, " full"}, 32'(prefetchFull), 32'(cnt == 3'd4));
  endtask

  logic [7:0] model_q[$];

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 20'h00000, 1'b0);

    //                 rst  psh   d      pop  fl   fa         sus   cnt   top    head       fetch      ovf  freq
    vecs.push_back(v(1'b1,1'b0,8'h00,1'b0,1'b0,20'h00000,1'b0,3'd0,8'h00,20'hFFFF0,20'hFFFF0,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b0,1'b0,20'h00000,1'b0,3'd0,8'h00,20'hFFFF0,20'hFFFF0,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'hEA,1'b0,1'b0,20'h00000,1'b0,3'd1,8'hEA,20'hFFFF0,20'hFFFF1,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h00,1'b0,1'b0,20'h00000,1'b0,3'd2,8'hEA,20'hFFFF0,20'hFFFF2,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h01,1'b0,1'b0,20'h00000,1'b0,3'd3,8'hEA,20'hFFFF0,20'hFFFF3,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h02,1'b0,1'b0,20'h00000,1'b0,3'd4,8'hEA,20'hFFFF0,20'hFFFF4,1'b0,1'b0));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd3,8'h00,20'hFFFF1,20'hFFFF4,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd2,8'h01,20'hFFFF2,20'hFFFF4,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd1,8'h02,20'hFFFF3,20'hFFFF4,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd0,8'h00,20'hFFFF4,20'hFFFF4,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd0,8'h00,20'hFFFF4,20'hFFFF4,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h11,1'b0,1'b0,20'h00000,1'b0,3'd1,8'h11,20'hFFFF4,20'hFFFF5,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h22,1'b0,1'b0,20'h00000,1'b0,3'd2,8'h11,20'hFFFF4,20'hFFFF6,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h33,1'b0,1'b0,20'h00000,1'b0,3'd3,8'h11,20'hFFFF4,20'hFFFF7,1'b0,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h44,1'b0,1'b0,20'h00000,1'b0,3'd4,8'h11,20'hFFFF4,20'hFFFF8,1'b0,1'b0));
    vecs.push_back(v(1'b0,1'b1,8'hAA,1'b1,1'b0,20'h00000,1'b0,3'd4,8'h22,20'hFFFF5,20'hFFFF9,1'b0,1'b0));
    vecs.push_back(v(1'b0,1'b1,8'hBB,1'b0,1'b0,20'h00000,1'b0,3'd4,8'h22,20'hFFFF5,20'hFFFF9,1'b1,1'b0));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd3,8'h33,20'hFFFF6,20'hFFFF9,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd2,8'h44,20'hFFFF7,20'hFFFF9,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd1,8'hAA,20'hFFFF8,20'hFFFF9,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h01,1'b0,1'b0,20'h00000,1'b0,3'd2,8'hAA,20'hFFFF8,20'hFFFFA,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h02,1'b0,1'b0,20'h00000,1'b0,3'd3,8'hAA,20'hFFFF8,20'hFFFFB,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h77,1'b1,1'b1,20'h12345,1'b0,3'd0,8'h00,20'h12345,20'h12345,1'b1,1'b0));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b0,1'b0,20'h00000,1'b0,3'd0,8'h00,20'h12345,20'h12345,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b0,1'b1,20'hFFFFE,1'b0,3'd0,8'h00,20'hFFFFE,20'hFFFFE,1'b1,1'b0));
    vecs.push_back(v(1'b0,1'b1,8'hC1,1'b0,1'b0,20'h00000,1'b0,3'd1,8'hC1,20'hFFFFE,20'hFFFFF,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'hC2,1'b0,1'b0,20'h00000,1'b0,3'd2,8'hC1,20'hFFFFE,20'h00000,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'hC3,1'b0,1'b0,20'h00000,1'b0,3'd3,8'hC1,20'hFFFFE,20'h00001,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd2,8'hC2,20'hFFFFF,20'h00001,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd1,8'hC3,20'h00000,20'h00001,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b1,1'b0,20'h00000,1'b0,3'd0,8'h00,20'h00001,20'h00001,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b1,8'h5A,1'b1,1'b0,20'h00000,1'b0,3'd1,8'h5A,20'h00001,20'h00002,1'b1,1'b1));
    vecs.push_back(v(1'b0,1'b0,8'h00,1'b0,1'b0,20'h00000,1'b1,3'd1,8'h5A,20'h00001,20'h00002,1'b1,1'b0));
    vecs.push_back(v(1'b1,1'b1,8'h6B,1'b1,1'b0,20'h00000,1'b0,3'd0,8'h00,20'hFFFF0,20'hFFFF0,1'b0,1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].rst, vecs[i].psh, vecs[i].d, vecs[i].pp, vecs[i].fl, vecs[i].fa, vecs[i].sus);
      @(posedge CLK);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].top, vecs[i].head,
                  vecs[i].fetch, vecs[i].ovf, vecs[i].freq);
    end

    // Full queue streaming: simultaneous push and pop keep count at 4 while pointers wrap.
    @(negedge CLK); drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 20'h00000, 1'b0);
    model_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); drive(1'b0, 1'b1, 8'h10 * 8'(i + 1), 1'b0, 1'b0, 20'h00000, 1'b0);
      model_q.push_back(8'h10 * 8'(i + 1));
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); drive(1'b0, 1'b1, 8'h50 + 8'(i), 1'b1, 1'b0, 20'h00000, 1'b0);
      void'(model_q.pop_front());
      model_q.push_back(8'h50 + 8'(i));
      @(posedge CLK);
      #1;
      check_state($sformatf("stream%0d", i), 3'd4, model_q[0], 20'hFFFF0 + 20'(i + 1),
                  20'hFFFF4 + 20'(i + 1), 1'b0, 1'b0);
    end

    // Head byte appears only after the push edge, never combinationally.
    @(negedge CLK); drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 20'h00000, 1'b0);
    @(negedge CLK); drive(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 20'h00000, 1'b0);
    #1;
    chk("nobypass top_before", 32'(prefetchTop), 32'h00);
    chk("nobypass empty_before", 32'(prefetchEmpty), 32'h1);
    @(posedge CLK);
    #1;
    chk("nobypass top_after", 32'(prefetchTop), 32'h5A);
    chk("nobypass count_after", 32'(count), 32'h1);

    @(negedge CLK); drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 20'h00000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- 8088 instruction prefetch queue.
- Sits between the bus interface, which fetches code bytes, and the execution unit, which consumes them.
- Buffers up to DEPTH bytes and tracks the 20-bit linear address of the head byte and of the next fetch.
- Supports flush on jumps and fetch suspension for EU bus cycles.

Parameters:
DEPTH, 4, queue capacity in bytes (8088 = 4; power of two, 2..8)
ADDR_W, 20, linear address width
RESET_ADDR, 20'hFFFF0, linear address loaded on reset (FFFF:0000)

Ports:
CLK  input  1  single clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
push  input  1  bus interface delivers a fetched code byte this cycle
pushData  input  8  fetched byte
pop  input  1  EU consumes head byte (advanceTop)
flush  input  1  discard queue contents and restart fetch at flushAddress
flushAddress  input  ADDR_W  new linear fetch address (CS*16+IP)
suspend  input  1  EU requests no new code fetches
prefetchTop  output  8  head byte
prefetchTopLinearAddress  output  ADDR_W  linear address of head byte
fetchAddress  output  ADDR_W  linear address of next byte to fetch
count  output  $clog2(DEPTH+1)  bytes held
prefetchEmpty  output  1  count==0
prefetchFull  output  1  count==DEPTH
fetchRequest  output  1  combinational: !prefetchFull && !suspend && !flush
overflow  output  1  sticky: push attempted while full without pop

Behaviour:
- Storage: DEPTH x 8 circular buffer with write pointer, read pointer and count registers. Pointers wrap modulo DEPTH.
- Reset (RESET high at clock edge; overrides everything):
  - count=0, pointers=0.
  - fetchAddress = prefetchTopLinearAddress = RESET_ADDR.
  - overflow=0; prefetchTop=8'h00.
- Priority per edge: RESET > flush > push/pop.
- Flush:
  - count=0, pointers=0.
  - fetchAddress = prefetchTopLinearAddress = flushAddress.
  - Concurrent push and pop are discarded.
  - overflow is unchanged.
- Push accept condition: push && (count<DEPTH || pop-accepted).
  - On accept: write pushData at write pointer, advance write pointer, fetchAddress += 1.
- Pop accept condition: pop && count>0, evaluated on pre-edge count.
  - On accept: advance read pointer, prefetchTopLinearAddress += 1.
- Push and pop both accepted in the same cycle: count unchanged.
  - Full + pop + push is legal: no overflow, count stays DEPTH.
- Pop when empty: ignored, even if push is accepted the same cycle. The pushed byte becomes head next cycle.
- Push when full without pop: byte dropped, fetchAddress unchanged, overflow set to 1. Cleared only by RESET.
- Address arithmetic: modulo 2^ADDR_W, so 20'hFFFFF + 1 = 20'h00000. No segment wrap handling; the bus interface supplies linear addresses.
- Invariant outside flush/reset: fetchAddress - prefetchTopLinearAddress == count (mod 2^ADDR_W).
- prefetchTop:
  - Combinational read of buffer at read pointer when count>0.
  - 8'h00 when empty.
  - Data is visible the cycle after the push edge (no same-cycle bypass).
- prefetchEmpty and prefetchFull decode from the count register (registered-state outputs, no combinational input path).
- Latency: byte pushed at edge N is available as prefetchTop after edge N when it is the head.

Test Plan:
- Reset then idle -> count=0, prefetchEmpty=1, prefetchTop=00, prefetchTopLinearAddress=fetchAddress=FFFF0, fetchRequest=1.
- Push EA,00,01,02 on four consecutive cycles -> count=4, prefetchFull=1, fetchRequest=0, fetchAddress=FFFF4, prefetchTop=EA at FFFF0. Then pop x4 -> tops 00,01,02 at FFFF1..FFFF3, then empty with head address FFFF4.
- Full queue; push AA with pop in the same cycle -> count=4, overflow=0, AA at tail. Then a push without pop -> overflow=1, byte dropped, fetchAddress unchanged.
- Flush with flushAddress=12345 while push and pop are also asserted on a 3-byte queue -> count=0, both addresses=12345, pushed byte absent.
- Flush to FFFFE, push 3 bytes -> fetchAddress=00001. Pop 2 -> prefetchTopLinearAddress=00000.
- Empty queue with pop and push 5A in the same cycle -> count=1, prefetchTop=5A, head address unchanged. Suspend=1 -> fetchRequest=0. Assert RESET mid-sequence -> all reset values restored on the next edge.
